// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer and the ALU it borrows.
`timescale 1ns/1ps
package muldiv_sequencer_pkg;

  localparam int MULDIV_ITERS = 32;
  localparam int WORD_W       = 32;

  typedef enum logic {MD_MULT, MD_DIV} muldiv_op_t;

  typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_DONE} muldiv_state_t;

  // Shared ALU opcodes; the sequencer only ever issues ALU_ADD and ALU_SUB.
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  // Two's-complement negate of a word.
  function automatic logic [WORD_W-1:0] neg_word(input logic [WORD_W-1:0] v);
    return (~v) + WORD_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_sign.sv
// Sign handling for signed MULT/DIV: operand magnitudes on entry and
// result fix-up (product/quotient negate, remainder follows dividend) on exit.
`timescale 1ns/1ps
module muldiv_sign
  import muldiv_sequencer_pkg::*;
(
  input  logic        is_signed,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] abs_a,
  output logic [31:0] abs_b,
  output logic        neg_res,
  output logic        neg_rem,
  input  muldiv_op_t  op,
  input  logic        fix_res,
  input  logic        fix_rem,
  input  logic [31:0] raw_hi,
  input  logic [31:0] raw_lo,
  output logic [31:0] fix_hi,
  output logic [31:0] fix_lo
);

  logic [63:0] prod_neg;

  // Operand magnitudes and the result signs recorded at issue.
  always_comb begin
    abs_a   = (is_signed && opa[31]) ? neg_word(opa) : opa;
    abs_b   = (is_signed && opb[31]) ? neg_word(opb) : opb;
    neg_res = is_signed & (opa[31] ^ opb[31]);
    neg_rem = is_signed & opa[31];
  end

  // Product negates as one 64-bit value; quotient and remainder independently.
  always_comb begin
    prod_neg = (~{raw_hi, raw_lo}) + 64'd1;
    fix_hi   = raw_hi;
    fix_lo   = raw_lo;
    if (op == MD_MULT) begin
      if (fix_res) begin
        fix_hi = prod_neg[63:32];
        fix_lo = prod_neg[31:0];
      end
    end else begin
      if (fix_res) fix_lo = neg_word(raw_lo);
      if (fix_rem) fix_hi = neg_word(raw_hi);
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine. Borrows the shared ALU for one
// add (shift-add multiply) or subtract (restoring divide) per cycle.
// Optional: MULDIV_SIGNED_EN builds signed support; otherwise every op is unsigned.
`timescale 1ns/1ps
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int ITERS = MULDIV_ITERS
)(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic        is_signed,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output aluop_t      aluop,
  output logic [31:0] porta,
  output logic [31:0] portb,
  input  logic [31:0] outport
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  muldiv_state_t    state_q;
  logic [CNT_W-1:0] count_q;
  muldiv_op_t       op_q;
  logic [31:0]      p_hi;   // MULT: product high / DIV: remainder R
  logic [31:0]      p_lo;   // MULT: product low (multiplier) / DIV: quotient Q
  logic [31:0]      m_q;    // MULT: multiplicand / DIV: divisor
  logic             neg_res_q, neg_rem_q;

  logic [31:0] abs_a, abs_b, fix_hi, fix_lo, step_hi, step_lo, sh;
  logic        neg_res, neg_rem, carry;

`ifdef MULDIV_SIGNED_EN
  muldiv_sign u_sign (
    .is_signed (is_signed),
    .opa       (opa),
    .opb       (opb),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_res   (neg_res),
    .neg_rem   (neg_rem),
    .op        (op_q),
    .fix_res   (neg_res_q),
    .fix_rem   (neg_rem_q),
    .raw_hi    (step_hi),
    .raw_lo    (step_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );
`else
  logic unused_signed;
  assign unused_signed = is_signed;
  assign abs_a   = opa;
  assign abs_b   = opb;
  assign neg_res = 1'b0;
  assign neg_rem = 1'b0;
  assign fix_hi  = step_hi;
  assign fix_lo  = step_lo;
`endif

  // Restoring-divide shift: remainder picks up the next dividend bit.
  assign sh = {p_hi[30:0], p_lo[31]};

  // ALU-side drive; depends on registers only so the ALU loop stays acyclic.
  always_comb begin
    aluop = ALU_ADD;
    porta = '0;
    portb = '0;
    if (state_q == MD_ITER) begin
      if (op_q == MD_MULT) begin
        porta = p_hi;
        portb = p_lo[0] ? m_q : '0;
      end else begin
        aluop = ALU_SUB;
        porta = sh;
        portb = m_q;
      end
    end
  end

  // Next P/R/Q from this cycle's ALU result.
  always_comb begin
    carry   = 1'b0;
    step_hi = p_hi;
    step_lo = p_lo;
    if (op_q == MD_MULT) begin
      carry   = (outport < p_hi);
      step_hi = {carry, outport[31:1]};
      step_lo = {outport[0], p_lo[31:1]};
    end else if (p_hi[31] || !(sh < m_q)) begin
      step_hi = outport;
      step_lo = {p_lo[30:0], 1'b1};
    end else begin
      step_hi = sh;
      step_lo = {p_lo[30:0], 1'b0};
    end
  end

  // Sequencer FSM with registered status and results.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      op_q      <= MD_MULT;
      p_hi      <= '0;
      p_lo      <= '0;
      m_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            count_q   <= '0;
            op_q      <= op;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            busy      <= 1'b1;
            if (op == MD_DIV && opb == '0) begin
              hi       <= opa;
              lo       <= '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_q  <= MD_DONE;
            end else begin
              div_zero <= 1'b0;
              p_hi     <= '0;
              p_lo     <= (op == MD_MULT) ? abs_b : abs_a;
              m_q      <= (op == MD_MULT) ? abs_a : abs_b;
              state_q  <= MD_ITER;
            end
          end
        end
        MD_ITER: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= MD_IDLE;
          end else if (count_q == LAST) begin
            hi      <= fix_hi;
            lo      <= fix_lo;
            done    <= 1'b1;
            state_q <= MD_DONE;
          end else begin
            p_hi    <= step_hi;
            p_lo    <= step_lo;
            count_q <= count_q + 1'b1;
          end
        end
        MD_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

endmodule
